delay_table_scheduler: RTL and testbench

//  Replays the four per-port delay tables filled by the host UART receiver. On a start pulse it

---
 rtl/delay_table_scheduler_pkg.sv | 18 +
 rtl/delay_table_scheduler_if.sv | 28 ++
 rtl/delay_table_scheduler_seq.sv | 109 ++++++++++
 rtl/delay_table_scheduler.sv | 80 ++++++++
 tb/tb_delay_table_scheduler.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_table_scheduler_pkg.sv
// Shared definitions for the delay-table replay scheduler: sizes and the
// per-port channel state encoding.
package delay_table_scheduler_pkg;

  localparam int NCH        = 4;
  localparam int AW         = 11;
  localparam int DW         = 24;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_FETCH,
    CH_WAIT,
    CH_FIRE,
    CH_FIN
  } ch_state_e;

endpackage

// File: rtl/delay_table_scheduler_if.sv
// Host/RAM/player bundle of the delay-table scheduler. The scheduler is the
// slave; the controller, RAM read ports and players together form the master.
interface delay_table_scheduler_if;
  import delay_table_scheduler_pkg::*;

  logic                    I_START;
  logic                    I_ABORT;
  logic [NCH-1:0]          I_CH_EN;
  logic [NCH-1:0][AW-1:0]  I_LEN;
  logic [NCH-1:0][AW-1:0]  O_RD_ADDR;
  logic [NCH-1:0][DW-1:0]  I_RD_DATA;
  logic [NCH-1:0]          O_TRIG;
  logic [NCH-1:0][AW-1:0]  O_WAVE_ID;
  logic [NCH-1:0]          O_LATE;
  logic                    O_BUSY;
  logic                    O_DONE;

  modport slave (
    input  I_START, I_ABORT, I_CH_EN, I_LEN, I_RD_DATA,
    output O_RD_ADDR, O_TRIG, O_WAVE_ID, O_LATE, O_BUSY, O_DONE
  );

  modport master (
    output I_START, I_ABORT, I_CH_EN, I_LEN, I_RD_DATA,
    input  O_RD_ADDR, O_TRIG, O_WAVE_ID, O_LATE, O_BUSY, O_DONE
  );

endinterface

// File: rtl/delay_table_scheduler_seq.sv
// delay_channel_seq: one port's replay FSM. Walks addresses 1..len, waits
// for each entry's absolute time and pulses a trigger tagged with the address.
module delay_channel_seq
  import delay_table_scheduler_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [AW-1:0] i_len,
  input  logic [DW-1:0] i_timer,
  input  logic [DW-1:0] i_rd_data,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_trig,
  output logic [AW-1:0] o_wave_id,
  output logic          o_late,
  output logic          o_fin
);

  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  ch_state_e       r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_len;
  logic [AW-1:0]   r_wave;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_d;
  logic            r_first;
  logic            r_late;
  logic [DW-1:0]   w_d;
  logic            w_match;

  // The first WAIT cycle is the one where RAM data is valid; later cycles use the latched copy.
  assign w_d     = r_first ? i_rd_data : r_d;
  assign w_match = (w_d <= i_timer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_wave  <= '0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_first <= 1'b0;
      r_late  <= 1'b0;
    end else begin
      r_wave <= '0;
      if (i_clr) begin
        r_state <= CH_IDLE;
      end else begin
        case (r_state)
          CH_IDLE: begin
            if (i_start) begin
              r_late  <= 1'b0;
              r_len   <= i_len;
              r_addr  <= AW'(1);
              r_cnt   <= '0;
              r_first <= 1'b0;
              r_state <= (i_en && i_len != '0) ? CH_FETCH : CH_FIN;
            end
          end
          CH_FETCH: begin
            if (r_cnt == CW'(RD_LAT - 1)) begin
              r_state <= CH_WAIT;
              r_first <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          CH_WAIT: begin
            r_first <= 1'b0;
            r_d     <= w_d;
            if (w_match) begin
              r_state <= CH_FIRE;
              r_wave  <= r_addr;
              r_addr  <= r_addr + AW'(1);
              if (w_d < i_timer) r_late <= 1'b1;
            end
          end
          CH_FIRE: begin
            // The FIRE cycle already presents the next address, so it counts as the first read cycle.
            if (r_wave >= r_len) begin
              r_state <= CH_FIN;
            end else if (RD_LAT == 1) begin
              r_state <= CH_WAIT;
              r_first <= 1'b1;
            end else begin
              r_state <= CH_FETCH;
              r_cnt   <= CW'(1);
            end
          end
          CH_FIN:  r_state <= CH_FIN;
          default: r_state <= CH_IDLE;
        endcase
      end
    end
  end

  assign o_rd_addr = r_addr;
  assign o_trig    = (r_state == CH_FIRE);
  assign o_wave_id = r_wave;
  assign o_late    = r_late;
  assign o_fin     = (r_state == CH_FIN) || ((r_state == CH_FIRE) && (r_wave >= r_len));

endmodule

// File: rtl/delay_table_scheduler.sv
// Replays the per-port delay tables: owns the run timer, start/abort control,
// done aggregation and busy flag; one delay_channel_seq per port.
module delay_table_scheduler
  import delay_table_scheduler_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  delay_table_scheduler_if.slave  bus
);

  logic [DW-1:0]          r_timer;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_start;
  logic                   w_clr;
  logic                   w_any_act;
  logic [NCH-1:0]         w_fin;
  logic [NCH-1:0]         w_trig;
  logic [NCH-1:0]         w_late;
  logic [NCH-1:0][AW-1:0] w_rd_addr;
  logic [NCH-1:0][AW-1:0] w_wave_id;

  assign w_start = bus.I_START & ~bus.I_ABORT & ~r_busy;
  assign w_clr   = bus.I_ABORT | r_done;

  always_comb begin
    w_any_act = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      if (bus.I_CH_EN[n] && bus.I_LEN[n] != '0) w_any_act = 1'b1;
    end
  end

  // Done is raised on the edge where the last channel enters FIN, so it coincides with FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.I_ABORT) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_busy  <= 1'b1;
      r_done  <= ~w_any_act;
      r_timer <= '0;
    end else begin
      r_done <= r_busy & ~r_done & (&w_fin);
      if (r_done) r_busy <= 1'b0;
      if (r_busy && r_timer != '1) r_timer <= r_timer + DW'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    delay_channel_seq #(.RD_LAT(RD_LAT)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_start),
      .i_clr     (w_clr),
      .i_en      (bus.I_CH_EN[g]),
      .i_len     (bus.I_LEN[g]),
      .i_timer   (r_timer),
      .i_rd_data (bus.I_RD_DATA[g]),
      .o_rd_addr (w_rd_addr[g]),
      .o_trig    (w_trig[g]),
      .o_wave_id (w_wave_id[g]),
      .o_late    (w_late[g]),
      .o_fin     (w_fin[g])
    );
  end

  assign bus.O_RD_ADDR = w_rd_addr;
  assign bus.O_TRIG    = w_trig;
  assign bus.O_WAVE_ID = w_wave_id;
  assign bus.O_LATE    = w_late;
  assign bus.O_BUSY    = r_busy;
  assign bus.O_DONE    = r_done;

endmodule

// File: tb/tb_delay_table_scheduler.sv
// Scoreboard bench for delay_table_scheduler: directed runs push expected
// trigger/done events; a negedge monitor pops and compares them.
module tb_delay_table_scheduler;
  import delay_table_scheduler_pkg::*;

  typedef struct {
    int cyc;
    int wave;
  } trig_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   now;
  int   k;
  int   dexp;
  trig_t e;

  trig_t q_trig [NCH][$];
  int    q_done [$];

  logic [DW-1:0]          mem [NCH][2048];
  logic [NCH-1:0][DW-1:0] r_p1;

  delay_table_scheduler_if bus ();

  delay_table_scheduler #(.RD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage RAM read model: address sampled, registered, then presented.
  always @(posedge clk) begin
    for (int p = 0; p < NCH; p++) begin
      r_p1[p]          <= mem[p][bus.O_RD_ADDR[p]];
      bus.I_RD_DATA[p] <= r_p1[p];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      now = cyc + 1;
      for (int p = 0; p < NCH; p++) begin
        if (bus.O_TRIG[p]) begin
          n_vec++;
          if (q_trig[p].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_trig port%0d: got trigger at cycle %0d wave %0d, required none", p, now, bus.O_WAVE_ID[p]);
          end else begin
            e = q_trig[p].pop_front();
            if (now != e.cyc || int'(bus.O_WAVE_ID[p]) != e.wave) begin
              n_err++;
              $display("FAIL trig port%0d: got cycle %0d wave %0d, required cycle %0d wave %0d", p, now, bus.O_WAVE_ID[p], e.cyc, e.wave);
            end
          end
        end
      end
      if (bus.O_DONE) begin
        n_vec++;
        if (q_done.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got pulse at cycle %0d, required none", now);
        end else begin
          dexp = q_done.pop_front();
          if (now != dexp) begin
            n_err++;
            $display("FAIL done: got cycle %0d, required cycle %0d", now, dexp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_empty(input string name);
    for (int p = 0; p < NCH; p++) begin
      check({name, "_pending_trig"}, 64'(q_trig[p].size()), 64'd0);
      q_trig[p].delete();
    end
    check({name, "_pending_done"}, 64'(q_done.size()), 64'd0);
    q_done.delete();
  endtask

  task automatic push_trig(input int p, input int c, input int w);
    trig_t t;
    t.cyc  = c;
    t.wave = w;
    q_trig[p].push_back(t);
  endtask

  task automatic load_table(input int p, input int d1, input int d2, input int d3);
    mem[p][1] = DW'(d1);
    mem[p][2] = DW'(d2);
    mem[p][3] = DW'(d3);
  endtask

  // Called at a negedge; the following posedge is edge k = cyc+1.
  task automatic start_run(input logic [NCH-1:0] en, input int l0, input int l1, input int l2, input int l3);
    bus.I_CH_EN  = en;
    bus.I_LEN[0] = AW'(l0);
    bus.I_LEN[1] = AW'(l1);
    bus.I_LEN[2] = AW'(l2);
    bus.I_LEN[3] = AW'(l3);
    bus.I_START  = 1'b1;
    @(negedge clk);
    bus.I_START  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc + 1 < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bus.I_START = 1'b0;
    bus.I_ABORT = 1'b0;
    bus.I_CH_EN = '0;
    bus.I_LEN   = '0;
    for (int p = 0; p < NCH; p++) begin
      for (int a = 0; a < 2048; a++) mem[p][a] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy",    64'(bus.O_BUSY),    64'd0);
    check("rst_done",    64'(bus.O_DONE),    64'd0);
    check("rst_trig",    64'(bus.O_TRIG),    64'd0);
    check("rst_rd_addr", 64'(bus.O_RD_ADDR), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a run
    load_table(1, 0, 1, 0);
    k = cyc + 1;
    push_trig(1, k + 4, 1);
    start_run(4'b0010, 0, 2, 0, 0);
    check("midrst_busy_rise", 64'(bus.O_BUSY), 64'd1);
    wait_until(k + 6);
    check("midrst_late_before", 64'(bus.O_LATE), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",    64'(bus.O_BUSY),    64'd0);
    check("midrst_late",    64'(bus.O_LATE),    64'd0);
    check("midrst_trig",    64'(bus.O_TRIG),    64'd0);
    check("midrst_rd_addr", 64'(bus.O_RD_ADDR), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_empty("midrst");

    // Single port, on-time entries
    load_table(0, 10, 20, 35);
    k = cyc + 1;
    push_trig(0, k + 12, 1);
    push_trig(0, k + 22, 2);
    push_trig(0, k + 37, 3);
    q_done.push_back(k + 38);
    start_run(4'b0001, 3, 0, 0, 0);
    check("p0_busy_rise", 64'(bus.O_BUSY), 64'd1);
    wait_until(k + 42);
    check("p0_late", 64'(bus.O_LATE), 64'd0);
    check("p0_busy_end", 64'(bus.O_BUSY), 64'd0);
    check_empty("p0");

    // Late entries on port 1
    k = cyc + 1;
    push_trig(1, k + 4, 1);
    push_trig(1, k + 7, 2);
    q_done.push_back(k + 8);
    start_run(4'b0010, 0, 2, 0, 0);
    wait_until(k + 12);
    check("late_flag", 64'(bus.O_LATE), 64'h2);
    check_empty("late");

    // All ports, identical tables, lens 2/0/1/3
    load_table(0, 10, 20, 30);
    load_table(2, 10, 20, 30);
    load_table(3, 10, 20, 30);
    k = cyc + 1;
    push_trig(0, k + 12, 1);
    push_trig(0, k + 22, 2);
    push_trig(2, k + 12, 1);
    push_trig(3, k + 12, 1);
    push_trig(3, k + 22, 2);
    push_trig(3, k + 32, 3);
    q_done.push_back(k + 33);
    start_run(4'b1111, 2, 0, 1, 3);
    wait_until(k + 36);
    check("all_late", 64'(bus.O_LATE), 64'd0);
    check_empty("all");

    // Abort after port 0's first trigger; late flag survives
    load_table(0, 10, 20, 35);
    load_table(1, 0, 1, 0);
    k = cyc + 1;
    push_trig(1, k + 4, 1);
    push_trig(1, k + 7, 2);
    push_trig(0, k + 12, 1);
    start_run(4'b0011, 3, 2, 0, 0);
    wait_until(k + 13);
    bus.I_ABORT = 1'b1;
    @(negedge clk);
    bus.I_ABORT = 1'b0;
    check("abort_busy", 64'(bus.O_BUSY), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_late_kept", 64'(bus.O_LATE), 64'h2);
    check_empty("abort");
    k = cyc + 1;
    push_trig(0, k + 12, 1);
    push_trig(0, k + 22, 2);
    push_trig(0, k + 37, 3);
    q_done.push_back(k + 38);
    start_run(4'b0001, 3, 0, 0, 0);
    wait_until(k + 42);
    check("replay_late", 64'(bus.O_LATE), 64'd0);
    check_empty("replay");

    // Start while busy is ignored
    k = cyc + 1;
    push_trig(0, k + 12, 1);
    push_trig(0, k + 22, 2);
    push_trig(0, k + 37, 3);
    q_done.push_back(k + 38);
    start_run(4'b0001, 3, 0, 0, 0);
    wait_until(k + 5);
    bus.I_CH_EN = 4'b1111;
    bus.I_START = 1'b1;
    @(negedge clk);
    bus.I_START = 1'b0;
    wait_until(k + 42);
    check_empty("busy_start");

    // Start together with abort is dropped
    bus.I_CH_EN = 4'b0001;
    bus.I_START = 1'b1;
    bus.I_ABORT = 1'b1;
    @(negedge clk);
    bus.I_START = 1'b0;
    bus.I_ABORT = 1'b0;
    check("start_abort_busy", 64'(bus.O_BUSY), 64'd0);
    repeat (20) @(negedge clk);
    check_empty("start_abort");

    // All disabled, then all zero-length
    k = cyc + 1;
    q_done.push_back(k + 1);
    start_run(4'b0000, 3, 2, 1, 3);
    check("dis_busy_k1", 64'(bus.O_BUSY), 64'd1);
    @(negedge clk);
    check("dis_busy_k2", 64'(bus.O_BUSY), 64'd0);
    repeat (4) @(negedge clk);
    check_empty("dis");
    k = cyc + 1;
    q_done.push_back(k + 1);
    start_run(4'b1111, 0, 0, 0, 0);
    check("zlen_busy_k1", 64'(bus.O_BUSY), 64'd1);
    @(negedge clk);
    check("zlen_busy_k2", 64'(bus.O_BUSY), 64'd0);
    repeat (4) @(negedge clk);
    check_empty("zlen");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
